// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter: measures period and high time of sig_in in clk_in cycles, with stopped-clock timeout.
// Optional ratio lock detector enabled by defining LOCK_DETECT_EN.
module clk_ratio_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4,
    parameter int TOL         = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_ratio,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_period,
    output logic [CNT_W-1:0] m_high,
    output logic             m_overflow,
    output logic             m_overrun,
    output logic             locked,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    localparam logic [CNT_W-1:0] MAX = '1;
    state_t state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic sync_prev_q, ovr_pend_q;
    logic [CNT_W-1:0] per_q, hi_q, hi_d;
    logic sync, rise, cap, load;
    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~sync_prev_q;
    // A rise coinciding with the timeout wins and is captured normally.
    assign cap  = en && state_q == MEAS && (rise || per_q == MAX);
    assign load = cap && (!m_valid || m_ready);
    assign hi_d = hi_q + {{(CNT_W-1){1'b0}}, sync && hi_q != MAX};
    assign busy = state_q != IDLE;
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            sync_prev_q <= 1'b0;
            per_q       <= '0;
            hi_q        <= '0;
            ovr_pend_q  <= 1'b0;
            m_valid     <= 1'b0;
            m_period    <= '0;
            m_high      <= '0;
            m_overflow  <= 1'b0;
            m_overrun   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_prev_q <= sync;
            if (!en) begin
                state_q <= IDLE;
                per_q   <= '0;
                hi_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ARM;
                    ARM: if (rise) begin
                        state_q <= MEAS;
                        per_q   <= CNT_W'(1);
                        hi_q    <= CNT_W'(1);
                    end
                    default: if (rise) begin
                        per_q <= CNT_W'(1);
                        hi_q  <= CNT_W'(1);
                    end else if (per_q == MAX) begin
                        state_q <= ARM;
                        per_q   <= '0;
                        hi_q    <= '0;
                    end else begin
                        per_q <= per_q + CNT_W'(1);
                        hi_q  <= hi_d;
                    end
                endcase
            end
            if (load) begin
                m_valid    <= 1'b1;
                m_period   <= per_q;
                m_high     <= hi_q;
                m_overflow <= !rise;
                m_overrun  <= ovr_pend_q;
                ovr_pend_q <= 1'b0;
            end else if (cap) begin
                ovr_pend_q <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
`ifdef LOCK_DETECT_EN
    localparam int LW = $clog2(LOCK_CNT + 1);
    logic [LW-1:0] lock_q;
    logic [CNT_W-1:0] diff;
    assign diff = per_q >= exp_ratio ? per_q - exp_ratio : exp_ratio - per_q;
    // Dropped captures still count toward lock.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
            locked <= 1'b0;
        end else if (!en || (cap && (!rise || diff > CNT_W'(TOL)))) begin
            lock_q <= '0;
            locked <= 1'b0;
        end else if (cap) begin
            lock_q <= lock_q == LW'(LOCK_CNT) ? lock_q : lock_q + LW'(1);
            locked <= lock_q >= LW'(LOCK_CNT - 1);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{exp_ratio, LOCK_CNT != TOL};
    assign locked = 1'b0;
`endif
endmodule
